// File: rtl/bp_be_multi_issue_queue.sv
// bp_be_multi_issue_queue
// N-lane issue queue between the FE queue and the BE scheduler. Entries are
// enqueued up to lanes_p per cycle, read speculatively through a
// combinational dequeue window at the read pointer, and retired by commit
// count. Roll rewinds the read pointer to the commit pointer; clr flushes
// everything that has not been committed.
//
// Three pointers, each carrying one extra wrap bit above the index:
//   cptr <= rptr <= wptr   (modulo 2^ptr_width_lp)
//   [cptr, rptr) : read speculatively, awaiting commit
//   [rptr, wptr) : not yet read, presented on the dequeue lanes
module bp_be_multi_issue_queue #(
  parameter  int lanes_p       = 2,
  parameter  int entry_width_p = 128,
  parameter  int depth_p       = 16,
  localparam int ptr_width_lp  = $clog2(depth_p) + 1,
  localparam int cnt_width_lp  = $clog2(lanes_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,

  input  logic [lanes_p*entry_width_p-1:0] enq_data_i,
  input  logic [lanes_p-1:0]               enq_v_i,
  output logic                             enq_ready_o,

  output logic [lanes_p*entry_width_p-1:0] deq_data_o,
  output logic [lanes_p-1:0]               deq_v_o,
  input  logic [cnt_width_lp-1:0]          deq_cnt_i,

  input  logic [cnt_width_lp-1:0]          commit_cnt_i,
  input  logic                             roll_i,
  input  logic                             clr_i,

  output logic                             empty_o,
  output logic                             full_o,
  output logic [ptr_width_lp-1:0]          count_o
);

  localparam int idx_width_lp = $clog2(depth_p);

  logic [ptr_width_lp-1:0]  wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]  rptr_q, rptr_d;
  logic [ptr_width_lp-1:0]  cptr_q, cptr_d;

  logic [entry_width_p-1:0] mem_q [depth_p];

  logic [ptr_width_lp-1:0]  unread;      // wptr - rptr
  logic [ptr_width_lp-1:0]  speculative; // rptr - cptr
  logic [ptr_width_lp-1:0]  cptr_adv;
  logic [cnt_width_lp-1:0]  enq_cnt;
  logic [cnt_width_lp-1:0]  deq_avail;
  logic [lanes_p-1:0]       enq_v_inc;
  logic                     enq_fire;

  // Status flags come straight from the registered pointers; occupancy counts
  // everything not yet committed, so commits free space only a cycle later.
  assign count_o     = wptr_q - cptr_q;
  assign unread      = wptr_q - rptr_q;
  assign speculative = rptr_q - cptr_q;
  assign empty_o     = (rptr_q == wptr_q);
  assign full_o      = (count_o == ptr_width_lp'(depth_p));
  assign enq_ready_o = ((ptr_width_lp'(depth_p) - count_o) >= ptr_width_lp'(lanes_p));

  // A flush wins over any enqueue in the same cycle.
  assign enq_fire    = enq_ready_o & (|enq_v_i) & ~clr_i;

  // Number of valid enqueue lanes (lanes are contiguous from lane 0).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    enq_cnt = '0;
    for (int i = 0; i < lanes_p; i++) begin
      enq_cnt = enq_cnt + cnt_width_lp'(enq_v_i[i]);
    end
  end

  // Dequeue window: lane i shows the entry at rptr+i while it is unread.
  always_comb begin
    logic [idx_width_lp-1:0] rd_idx;
    deq_v_o    = '0;
    deq_data_o = '0;
    rd_idx     = '0;
    for (int i = 0; i < lanes_p; i++) begin
      rd_idx     = rptr_q[idx_width_lp-1:0] + idx_width_lp'(i);
      deq_v_o[i] = (ptr_width_lp'(i) < unread);
      deq_data_o[i*entry_width_p +: entry_width_p] = mem_q[rd_idx];
    end
  end

  // Pointer next state: clr beats roll, roll beats a normal dequeue.
  always_comb begin
    cptr_adv = cptr_q + ptr_width_lp'(commit_cnt_i);
    cptr_d   = cptr_adv;
    rptr_d   = rptr_q + ptr_width_lp'(deq_cnt_i);
    wptr_d   = enq_fire ? (wptr_q + ptr_width_lp'(enq_cnt)) : wptr_q;
    if (clr_i) begin
      rptr_d = cptr_adv;
      wptr_d = cptr_adv;
    end else if (roll_i) begin
      rptr_d = cptr_adv;
    end
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Entry storage: each valid lane lands at wptr+i; visible from the next cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
    for (int i = 0; i < lanes_p; i++) begin
      if (enq_fire && enq_v_i[i]) begin
        mem_q[wptr_q[idx_width_lp-1:0] + idx_width_lp'(i)] <=
          enq_data_i[i*entry_width_p +: entry_width_p];
      end
    end
  end

  // Interface-usage checks: contiguous enqueue lanes, no over-dequeue, no over-commit.
  assign enq_v_inc = enq_v_i + lanes_p'(1);
  assign deq_avail = (unread >= ptr_width_lp'(lanes_p)) ? cnt_width_lp'(lanes_p)
                                                       : unread[cnt_width_lp-1:0];

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert ((enq_v_i & enq_v_inc) == '0);
      assert (deq_cnt_i <= deq_avail);
      assert (ptr_width_lp'(commit_cnt_i) <= speculative);
    end
  end

endmodule

// File: tb/tb_bp_be_multi_issue_queue.sv
// Directed testbench for bp_be_multi_issue_queue (lanes_p=2, depth_p=16).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_bp_be_multi_issue_queue;

  localparam int lanes_p = 2;
  localparam int ew_p    = 128;
  localparam int depth_p = 16;

  logic               clk_i;
  logic               reset_i;
  logic [2*ew_p-1:0]  enq_data_i;
  logic [1:0]         enq_v_i;
  logic               enq_ready_o;
  logic [2*ew_p-1:0]  deq_data_o;
  logic [1:0]         deq_v_o;
  logic [1:0]         deq_cnt_i;
  logic [1:0]         commit_cnt_i;
  logic               roll_i;
  logic               clr_i;
  logic               empty_o;
  logic               full_o;
  logic [4:0]         count_o;

  int n_checks = 0;
  int n_errors = 0;

  bp_be_multi_issue_queue #(
    .lanes_p      (lanes_p),
    .entry_width_p(ew_p),
    .depth_p      (depth_p)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enq_data_i  (enq_data_i),
    .enq_v_i     (enq_v_i),
    .enq_ready_o (enq_ready_o),
    .deq_data_o  (deq_data_o),
    .deq_v_o     (deq_v_o),
    .deq_cnt_i   (deq_cnt_i),
    .commit_cnt_i(commit_cnt_i),
    .roll_i      (roll_i),
    .clr_i       (clr_i),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .count_o     (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [ew_p-1:0] obs, input logic [ew_p-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    enq_data_i   = '0;
    enq_v_i      = 2'b00;
    deq_cnt_i    = 2'd0;
    commit_cnt_i = 2'd0;
    roll_i       = 1'b0;
    clr_i        = 1'b0;
  endtask

  task automatic enq(input logic [1:0] v, input logic [ew_p-1:0] d0, input logic [ew_p-1:0] d1);
    enq_v_i    = v;
    enq_data_i = {d1, d0};
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, ew_p'(enq_ready_o), 1);
    check({tag, "_deq_v"}, ew_p'(deq_v_o), 0);
    check({tag, "_empty"}, ew_p'(empty_o), 1);
    check({tag, "_full"},  ew_p'(full_o), 0);
    check({tag, "_count"}, ew_p'(count_o), 0);
  endtask

  initial begin
    idle();
    reset_i = 1'b1;

    // Reset and idle
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state("in_reset");
    reset_i = 1'b0;
    tick();
    check_reset_state("idle");

    // Fill: seven pairs, then an eighth reaches full
    for (int k = 0; k < 7; k++) begin
      enq(2'b11, ew_p'(2*k), ew_p'(2*k+1));
      tick();
    end
    check("fill7_count", ew_p'(count_o), 14);
    check("fill7_ready", ew_p'(enq_ready_o), 1);
    enq(2'b11, ew_p'(14), ew_p'(15));
    tick();
    check("fill8_count", ew_p'(count_o), 16);
    check("fill8_full",  ew_p'(full_o), 1);
    check("fill8_ready", ew_p'(enq_ready_o), 0);
    check("fill8_deq_v", ew_p'(deq_v_o), 3);
    check("fill8_lane0", deq_data_o[ew_p-1:0], 0);
    check("fill8_lane1", deq_data_o[2*ew_p-1:ew_p], 1);
    enq(2'b11, ew_p'(8'hAA), ew_p'(8'hAB));
    tick();
    check("blocked_count", ew_p'(count_o), 16);
    check("blocked_lane0", deq_data_o[ew_p-1:0], 0);

    // Flush everything back to an empty queue
    idle();
    clr_i = 1'b1;
    tick();
    idle();
    check("flush_empty", ew_p'(empty_o), 1);
    check("flush_count", ew_p'(count_o), 0);
    check("flush_ready", ew_p'(enq_ready_o), 1);

    // Wrap: 40 entries stream through index and pointer wrap-around
    for (int k = 0; k < 20; k++) begin
      idle();
      enq(2'b11, ew_p'(16'h100 + 2*k), ew_p'(16'h101 + 2*k));
      commit_cnt_i = (k > 0) ? 2'd2 : 2'd0;
      tick();
      check($sformatf("wrap%0d_lane0", k), deq_data_o[ew_p-1:0], ew_p'(16'h100 + 2*k));
      check($sformatf("wrap%0d_lane1", k), deq_data_o[2*ew_p-1:ew_p], ew_p'(16'h101 + 2*k));
      check($sformatf("wrap%0d_count", k), ew_p'(count_o), 2);
      check($sformatf("wrap%0d_full", k), ew_p'(full_o), 0);
      idle();
      deq_cnt_i = 2'd2;
      tick();
      check($sformatf("wrap%0d_empty", k), ew_p'(empty_o), 1);
    end
    idle();
    commit_cnt_i = 2'd2;
    tick();
    idle();
    check("wrap_drained", ew_p'(count_o), 0);

    // Roll: A..F in, read A..D, commit A, roll back to B
    enq(2'b11, ew_p'(8'hA), ew_p'(8'hB)); tick();
    enq(2'b11, ew_p'(8'hC), ew_p'(8'hD)); tick();
    enq(2'b11, ew_p'(8'hE), ew_p'(8'hF)); tick();
    idle();
    deq_cnt_i = 2'd2; tick();
    deq_cnt_i = 2'd2; tick();
    check("roll_pre_lane0", deq_data_o[ew_p-1:0], ew_p'(8'hE));
    idle();
    commit_cnt_i = 2'd1; tick();
    idle();
    roll_i = 1'b1; tick();
    idle();
    check("roll_lane0", deq_data_o[ew_p-1:0], ew_p'(8'hB));
    check("roll_lane1", deq_data_o[2*ew_p-1:ew_p], ew_p'(8'hC));
    check("roll_deq_v", ew_p'(deq_v_o), 3);
    check("roll_count", ew_p'(count_o), 5);

    // clr together with commit, enqueue and dequeue
    deq_cnt_i = 2'd2; tick();
    idle();
    clr_i        = 1'b1;
    commit_cnt_i = 2'd1;
    deq_cnt_i    = 2'd2;
    enq(2'b11, ew_p'(8'h77), ew_p'(8'h78));
    tick();
    idle();
    check("clr_empty", ew_p'(empty_o), 1);
    check("clr_count", ew_p'(count_o), 0);
    check("clr_deq_v", ew_p'(deq_v_o), 0);
    check("clr_ready", ew_p'(enq_ready_o), 1);
    enq(2'b11, ew_p'(8'h55), ew_p'(8'h56));
    tick();
    check("post_clr_count", ew_p'(count_o), 2);
    check("post_clr_lane0", deq_data_o[ew_p-1:0], ew_p'(8'h55));
    check("post_clr_lane1", deq_data_o[2*ew_p-1:ew_p], ew_p'(8'h56));

    // Build occupancy to 9, then reset asynchronously between edges
    for (int k = 0; k < 3; k++) begin
      enq(2'b11, ew_p'(8'h60 + 2*k), ew_p'(8'h61 + 2*k));
      tick();
    end
    enq(2'b01, ew_p'(8'h66), ew_p'(0));
    tick();
    idle();
    check("burst_count", ew_p'(count_o), 9);
    #2;
    reset_i = 1'b1;
    #1;
    check_reset_state("async_rst");
    #2;
    reset_i = 1'b0;
    enq(2'b01, ew_p'(8'h99), ew_p'(0));
    #1;
    check("no_bypass_deq_v", ew_p'(deq_v_o), 0);
    tick();
    idle();
    check("after_rst_deq_v", ew_p'(deq_v_o), 1);
    check("after_rst_lane0", deq_data_o[ew_p-1:0], ew_p'(8'h99));
    check("after_rst_count", ew_p'(count_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
